mtimer: RTL and testbench

MTIMER -- requirements
Module: mtimer

---
 rtl/mtimer.sv | 157 +++++++++++++++
 tb/tb_mtimer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// mtimer: 64-bit machine timer (mtime/mtimecmp) with level interrupt.
// Define MTIMER_TICK_SYNC_EN to add a 2-flop synchronizer on tick_i.
module mtimer #(
  parameter int unsigned INC_STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        irq_o
);

  localparam logic [63:0] INC64 = 64'(INC_STEP);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_nxt;
  logic [63:0] cmp_nxt;

  logic        tick_src;
  logic        tick_q;
  logic        tick_edge;

  logic        sel_time_lo;
  logic        sel_time_hi;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;

  logic        wr_time_lo;
  logic        wr_time_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;

  logic [31:0] rd_mux;

`ifdef MTIMER_TICK_SYNC_EN
  logic [1:0]  tick_sync;

  // Two-flop synchronizer, preset high so reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_sync <= 2'b11;
    end else begin
      tick_sync <= {tick_sync[0], tick_i};
    end
  end

  assign tick_src = tick_sync[1];
`else
  assign tick_src = tick_i;
`endif

  // Delayed tick copy for rising-edge detection; preset high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick_src;
    end
  end

  assign tick_edge = tick_src & ~tick_q;

  // One-hot register select from the address.
  always_comb begin
    sel_time_lo = 1'b0;
    sel_time_hi = 1'b0;
    sel_cmp_lo  = 1'b0;
    sel_cmp_hi  = 1'b0;
    unique case (addr_i)
      2'd0: sel_time_lo = 1'b1;
      2'd1: sel_time_hi = 1'b1;
      2'd2: sel_cmp_lo  = 1'b1;
      2'd3: sel_cmp_hi  = 1'b1;
    endcase
  end

  assign wr_time_lo = wr_en_i & sel_time_lo;
  assign wr_time_hi = wr_en_i & sel_time_hi;
  assign wr_cmp_lo  = wr_en_i & sel_cmp_lo;
  assign wr_cmp_hi  = wr_en_i & sel_cmp_hi;

  // Next mtime: a write to either half drops a same-cycle increment.
  always_comb begin
    mtime_nxt = mtime;
    if (tick_edge) begin
      mtime_nxt = mtime + INC64;
    end
    if (wr_time_lo) begin
      mtime_nxt = {mtime[63:32], wdata_i};
    end
    if (wr_time_hi) begin
      mtime_nxt = {wdata_i, mtime[31:0]};
    end
  end

  // Next mtimecmp: only the addressed half changes.
  always_comb begin
    cmp_nxt = mtimecmp;
    if (wr_cmp_lo) begin
      cmp_nxt[31:0] = wdata_i;
    end
    if (wr_cmp_hi) begin
      cmp_nxt[63:32] = wdata_i;
    end
  end

  // Timer and compare registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= cmp_nxt;
    end
  end

  // Read mux sees pre-write register contents.
  always_comb begin
    rd_mux = 32'd0;
    unique case (addr_i)
      2'd0: rd_mux = mtime[31:0];
      2'd1: rd_mux = mtime[63:32];
      2'd2: rd_mux = mtimecmp[31:0];
      2'd3: rd_mux = mtimecmp[63:32];
    endcase
  end

  // Registered read port; rdata holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o  <= 32'd0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= rd_en_i;
      if (rd_en_i) begin
        rdata_o <= rd_mux;
      end
    end
  end

  // Interrupt level registered from current register values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: directed, table and random checks of mtimer
// against a cycle-level reference model.
module tb_mtimer;

`ifdef MTIMER_TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int unsigned INC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_irq;
  logic [3:0]  hist;

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  mtimer #(.INC_STEP(INC)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .tick_i  (tick),
    .wr_en_i (wr),
    .rd_en_i (rd),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .rvalid_o(rvalid),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [63:0] t;
    logic [63:0] c;
    logic [31:0] cur;
    logic        en;
    if (rst) begin
      m_time   = 64'd0;
      m_cmp    = '1;
      m_rdata  = 32'd0;
      m_rvalid = 1'b0;
      m_irq    = 1'b0;
      hist     = 4'hF;
    end else begin
      hist = {hist[2:0], tick};
      en   = hist[LAT-1] && !hist[LAT];
      case (addr)
        2'd0: cur = m_time[31:0];
        2'd1: cur = m_time[63:32];
        2'd2: cur = m_cmp[31:0];
        default: cur = m_cmp[63:32];
      endcase
      m_rvalid = rd;
      if (rd) m_rdata = cur;
      m_irq = (m_time >= m_cmp);
      t = en ? m_time + 64'(INC) : m_time;
      c = m_cmp;
      if (wr) begin
        case (addr)
          2'd0: t = {m_time[63:32], wdata};
          2'd1: t = {wdata, m_time[31:0]};
          2'd2: c[31:0] = wdata;
          default: c[63:32] = wdata;
        endcase
      end
      m_time = t;
      m_cmp  = c;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_rvalid", 64'(rvalid), 64'(m_rvalid));
    check("model_rdata", 64'(rdata), 64'(m_rdata));
    check("model_irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic do_write(input logic [1:0] a,
                          input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    cycle();
    wr = 1'b0;
  endtask

  task automatic do_read(input string name,
                         input logic [1:0] a,
                         input logic [31:0] exp);
    rd = 1'b1;
    addr = a;
    cycle();
    rd = 1'b0;
    check({name, "_rvalid"}, 64'(rvalid), 64'd1);
    check(name, 64'(rdata), 64'(exp));
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    repeat (4) cycle();
    tick = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin
    int first;

    tbl[0] = '{2'd2, 32'h0000_0010, 2'd2, 32'h0000_0010};
    tbl[1] = '{2'd3, 32'h0000_0001, 2'd3, 32'h0000_0001};
    tbl[2] = '{2'd0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF};
    tbl[3] = '{2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678};
    tbl[4] = '{2'd0, 32'h0000_0000, 2'd1, 32'h1234_5678};
    tbl[5] = '{2'd2, 32'hFFFF_FFFF, 2'd3, 32'h0000_0001};

    // reset state
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    repeat (4) cycle();
    do_read("rst_cmp_lo", 2'd2, 32'hFFFF_FFFF);
    do_read("rst_cmp_hi", 2'd3, 32'hFFFF_FFFF);

    // register write/readback table
    for (int i = 0; i < 6; i++) begin
      do_write(tbl[i].waddr, tbl[i].wdata);
      do_read($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
    end

    // same-cycle read and write return old contents
    wr = 1'b1;
    rd = 1'b1;
    addr = 2'd0;
    wdata = 32'hAAAA_5555;
    cycle();
    wr = 1'b0;
    rd = 1'b0;
    check("rw_same_old", 64'(rdata), 64'd0);
    do_read("rw_same_new", 2'd0, 32'hAAAA_5555);

    // counting and edge-to-increment latency
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (4) cycle();
    tick = 1'b1;
    rd = 1'b1;
    addr = 2'd0;
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (first == 0 && rvalid && rdata == 32'd1) first = k;
    end
    tick = 1'b0;
    rd = 1'b0;
    repeat (4) cycle();
    check("tick_latency", 64'(first), 64'(LAT + 1));
    repeat (4) tick_pulse();
    repeat (2) cycle();
    do_read("count5", 2'd0, 32'd5);
    cycle();
    check("count5_rvalid_drop", 64'(rvalid), 64'd0);
    check("count5_hold", 64'(rdata), 64'd5);

    // wrap
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd1, 32'hFFFF_FFFF);
    tick_pulse();
    do_read("wrap_hi", 2'd1, 32'd0);
    do_read("wrap_lo", 2'd0, 32'd0);

    // interrupt
    do_write(2'd2, 32'd3);
    do_write(2'd3, 32'd0);
    repeat (2) tick_pulse();
    check("irq_at2", 64'(irq), 64'd0);
    tick_pulse();
    check("irq_at3", 64'(irq), 64'd1);
    do_write(2'd2, 32'd10);
    check("irq_wr_plus1", 64'(irq), 64'd1);
    cycle();
    check("irq_wr_plus2", 64'(irq), 64'd0);

    // write to mtime collides with tick edge
    tick = 1'b1;
    repeat (LAT - 1) cycle();
    do_write(2'd0, 32'h0000_0100);
    repeat (4) cycle();
    do_read("collide_lo", 2'd0, 32'h0000_0100);
    do_read("collide_hi", 2'd1, 32'd0);
    check("pre_rst_irq", 64'(irq), 64'd1);

    // reset mid-count with tick held high
    rd = 1'b1;
    addr = 2'd0;
    cycle();
    rst = 1'b1;
    wr = 1'b1;
    wdata = 32'h55;
    cycle();
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_rdata", 64'(rdata), 64'd0);
    check("midrst_irq", 64'(irq), 64'd0);
    cycle();
    rst = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    repeat (6) cycle();
    do_read("midrst_cmp_lo", 2'd2, 32'hFFFF_FFFF);
    do_read("midrst_cmp_hi", 2'd3, 32'hFFFF_FFFF);
    do_read("midrst_noedge", 2'd0, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 200) == 0;
      if (($urandom % 3) == 0) tick = ~tick;
      wr = ($urandom % 5) == 0;
      rd = ($urandom % 5) < 2;
      addr = 2'($urandom % 4);
      wdata = ($urandom % 2) ? $urandom : $urandom_range(0, 6);
      cycle();
    end
    rst = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
